// File: rtl/imm_gen_pipe.sv
// Registered RV32 immediate generator with AES MMIO address immediates and 2-entry skid FIFO.
// Optional: define IMM_GEN_ZIMM_EN to decode sel 10 as the CSR zimm immediate.
module imm_gen_pipe #(
    parameter int          XLEN          = 32,
    parameter int          TAG_W         = 8,
    parameter int          NUM_AES_CH    = 2,
    parameter logic [31:0] AES_BASE      = 32'h4000_0000,
    parameter logic [31:0] AES_CH_STRIDE = 32'h0000_0100
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [24:0]      inst_i,
    input  logic [3:0]       imm_sel_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    logic [31:7]     ins;
    logic [2:0]      ch;
    logic [31:0]     v32;
    logic [31:0]     off;
    logic            sx;
    logic            aes;
    logic            err_d;
    logic [XLEN-1:0] imm_d;

    assign ins = inst_i;
    assign ch  = ins[14:12];

    always_comb begin
        v32   = '0;
        off   = '0;
        sx    = 1'b0;
        aes   = 1'b0;
        err_d = 1'b0;
        case (imm_sel_i)
            4'd0: begin
                v32 = {{20{ins[31]}}, ins[31:20]};
                sx  = 1'b1;
            end
            4'd1: begin
                v32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                sx  = 1'b1;
            end
            4'd2: begin
                v32 = {{19{ins[31]}}, ins[31], ins[7],
                       ins[30:25], ins[11:8], 1'b0};
                sx  = 1'b1;
            end
            4'd3: begin
                v32 = {{11{ins[31]}}, ins[31], ins[19:12],
                       ins[20], ins[30:21], 1'b0};
                sx  = 1'b1;
            end
            4'd4: v32 = {ins[31:12], 12'h000};
            4'd5: begin aes = 1'b1; off = 32'h10; end
            4'd6: begin aes = 1'b1; off = 32'h20; end
            4'd7: begin aes = 1'b1; off = 32'h00; end
            4'd8: begin aes = 1'b1; off = 32'h04; end
            4'd9: begin aes = 1'b1; off = 32'h30; end
`ifdef IMM_GEN_ZIMM_EN
            4'd10: v32 = {27'd0, ins[19:15]};
`endif
            default: err_d = 1'b1;
        endcase
        // channel address wraps modulo 2^32 and is never sign-extended
        if (aes) begin
            if (int'(ch) >= NUM_AES_CH) begin
                err_d = 1'b1;
            end else begin
                v32 = AES_BASE + 32'(ch) * AES_CH_STRIDE + off;
            end
        end
        if (err_d) begin
            imm_d = '0;
        end else if (sx) begin
            imm_d = XLEN'($signed(v32));
        end else begin
            imm_d = XLEN'(v32);
        end
    end

    entry_t     mem [2];
    entry_t     head;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready_o  = (count != 2'd2);
    assign out_valid_o = (count != 2'd0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush_i) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {imm_d, tag_i, err_d};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign imm_o = out_valid_o ? head.imm : '0;
    assign tag_o = out_valid_o ? head.tag : '0;
    assign err_o = out_valid_o ? head.err : 1'b0;

endmodule
